// File: rtl/suma_c2_seg.sv
// suma_c2_seg: pipelined ANCHO-bit two's-complement add/sub split into ETAPAS carry segments with valid/ready stall; ports clk,rst,a,b,ci,op,in_valid -> in_ready; s,coutfin,ovf,out_valid <- out_ready; define SUMAC2_SAT_EN to saturate s on ovf
module suma_c2_seg #(
  parameter int ANCHO  = 64,
  parameter int ETAPAS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             ci,
  input  logic             op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ANCHO-1:0] s,
  output logic             coutfin,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int W = ANCHO / ETAPAS;
  logic [ETAPAS:0] v, c;
  logic [ANCHO-1:0] ra [0:ETAPAS-1];
  logic [ANCHO-1:0] rb [0:ETAPAS-1];
  logic [ANCHO-1:0] rs [1:ETAPAS];
  logic [ANCHO-1:0] nx [1:ETAPAS];
  logic [W:0] sm [1:ETAPAS];
  logic [ANCHO-1:0] fin;
  logic adv, sa, of_raw, ovf_q;
  assign adv = !v[ETAPAS] || out_ready;
  assign in_ready = adv;
  assign out_valid = v[ETAPAS];
  assign s = rs[ETAPAS];
  assign coutfin = c[ETAPAS];
  assign ovf = ovf_q;
  always_comb begin
    for (int k = 1; k <= ETAPAS; k++) begin
      sm[k] = {1'b0, ra[k-1][(k-1)*W +: W]} + {1'b0, rb[k-1][(k-1)*W +: W]} + {{W{1'b0}}, c[k-1]};
      nx[k] = '0;
    end
    for (int k = 2; k <= ETAPAS; k++) nx[k] = rs[k-1];
    for (int k = 1; k <= ETAPAS; k++) nx[k][(k-1)*W +: W] = sm[k][W-1:0];
    sa = ra[ETAPAS-1][ANCHO-1];
    of_raw = (sa == rb[ETAPAS-1][ANCHO-1]) && (nx[ETAPAS][ANCHO-1] != sa);
`ifdef SUMAC2_SAT_EN
    fin = of_raw ? {sa, {(ANCHO-1){!sa}}} : nx[ETAPAS];
`else
    fin = nx[ETAPAS];
`endif
  end
  // stage 0 only captures the conditioned operands; stage k resolves slice k-1
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      c <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < ETAPAS; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
      end
      for (int k = 1; k <= ETAPAS; k++) rs[k] <= '0;
    end else if (adv) begin
      v <= {v[ETAPAS-1:0], in_valid};
      c[0] <= op ^ ci;
      ra[0] <= a;
      rb[0] <= op ? ~b : b;
      for (int k = 1; k <= ETAPAS; k++) c[k] <= sm[k][W];
      for (int k = 1; k < ETAPAS; k++) begin
        ra[k] <= ra[k-1];
        rb[k] <= rb[k-1];
        rs[k] <= nx[k];
      end
      rs[ETAPAS] <= fin;
      ovf_q <= of_raw;
    end
  end
endmodule

// File: tb/tb_suma_c2_seg.sv
// tb_suma_c2_seg: randomized and directed check of suma_c2_seg against a full-width arithmetic model
module tb_suma_c2_seg;
  localparam int ANCHO = 64, ETAPAS = 4;
`ifdef SUMAC2_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
  logic clk = 0, rst = 1;
  logic [63:0] a = '0, b = '0;
  logic ci = 0, op = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, coutfin, ovf;
  logic [63:0] s;
  int total = 0, bad = 0;
  typedef struct {logic [63:0] s; logic c; logic o;} exp_t;
  exp_t q[$];
  logic [63:0] got[$];
  logic hold_p = 0, pc = 0, po = 0;
  logic [63:0] ps = '0;

  suma_c2_seg #(.ANCHO(ANCHO), .ETAPAS(ETAPAS)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ci(ci), .op(op),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .coutfin(coutfin),
    .ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // true integer arithmetic: wide signed value for ovf, wide unsigned value for carry/borrow
  function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic cin, input logic sub);
    exp_t e;
    logic signed [65:0] t;
    logic [65:0] u;
    t = sub ? $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}) - $signed({65'd0, cin})
            : $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}) + $signed({65'd0, cin});
    u = sub ? {2'b0, x} - {2'b0, y} - {65'd0, cin} : {2'b0, x} + {2'b0, y} + {65'd0, cin};
    e.o = (t > $signed({2'b0, MAXP})) || (t < -$signed({2'b0, MINN}));
    e.c = sub ? !u[65] : u[64];
    e.s = (SAT && e.o) ? (x[63] ? MINN : MAXP) : t[63:0];
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back(model(a, b, ci, op));
  end

  always @(negedge clk) begin
    if (rst) hold_p = 0;
    else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, !out_valid || out_ready});
      if (hold_p && out_valid) begin
        chk("held_s", s, ps);
        chk("held_flags", {62'd0, coutfin, ovf}, {62'd0, pc, po});
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got s=%h want no result", s);
        end else begin
          chk("s", s, q[0].s);
          chk("coutfin", {63'd0, coutfin}, {63'd0, q[0].c});
          chk("ovf", {63'd0, ovf}, {63'd0, q[0].o});
          if (out_ready) begin
            got.push_back(s);
            void'(q.pop_front());
          end
        end
      end
      hold_p = out_valid && !out_ready;
      ps = s;
      pc = coutfin;
      po = ovf;
    end
  end

  // caller is at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic cin, input logic sub);
    logic ok;
    a = x;
    b = y;
    ci = cin;
    op = sub;
    in_valid = 1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic get_one(output logic [63:0] rs, output logic rc, output logic ro, output int lat);
    logic ok;
    ok = 0;
    lat = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
      else lat++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL result_timeout: got out_valid=0 want 1");
    end
    rs = s;
    rc = coutfin;
    ro = ovf;
  endtask

  task automatic dir(input string nm, input logic [63:0] x, input logic [63:0] y, input logic cin,
                     input logic sub, input logic [63:0] es, input logic ec, input logic eo);
    logic [63:0] rs;
    logic rc, ro;
    int lat;
    @(posedge clk);
    #1 send(x, y, cin, sub);
    get_one(rs, rc, ro, lat);
    chk({nm, "_s"}, rs, es);
    chk({nm, "_cout"}, {63'd0, rc}, {63'd0, ec});
    chk({nm, "_ovf"}, {63'd0, ro}, {63'd0, eo});
    chk({nm, "_lat"}, 64'(lat), 64'(ETAPAS));
  endtask

  function automatic logic [63:0] rnd();
    int k;
    k = $urandom_range(0, 7);
    return k == 0 ? MINN : k == 1 ? MAXP : k == 2 ? '1 : k == 3 ? '0 : {$urandom, $urandom};
  endfunction

  initial begin
    logic hold, ok;
    logic [63:0] h;
    int nv;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_s", s, 64'd0);
    chk("rst_flags", {62'd0, coutfin, ovf}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    dir("wrap", '1, 64'd1, 0, 0, 64'd0, 1, 0);
    @(negedge clk);
    chk("wrap_one_cycle", {63'd0, out_valid}, 64'd0);
    dir("sub_ci0", 64'd1, 64'd1, 0, 1, 64'd0, 1, 0);
    dir("sub_ci1", 64'd1, 64'd1, 1, 1, '1, 0, 0);
    dir("neg_ovf", MINN, MINN, 0, 0, SAT ? MINN : 64'd0, 1, 1);
    dir("pos_ovf", MAXP, 64'd1, 0, 0, SAT ? MAXP : MINN, 0, 1);

    @(posedge clk);
    #1 got.delete();
    fork
      begin
        for (int i = 1; i <= 8; i++) send(64'(i), 64'(i), 0, 0);
      end
      begin
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
          @(negedge clk);
          ok = out_valid;
        end
        @(posedge clk);
        #1 out_ready = 0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          if (j == 0) h = s;
          chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
          chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
          chk("bp_stable", s, h);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    for (int i = 0; i < 100 && got.size() < 8; i++) @(negedge clk);
    chk("bp_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("bp_order", got[i], 64'(2 * (i + 1)));

    @(posedge clk);
    #1 send(64'd100, 64'd1, 0, 0);
    send(64'd200, 64'd2, 0, 0);
    send(64'd300, 64'd3, 0, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_s", s, 64'd0);
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("mid_rst_ghosts", 64'(nv), 64'd0);
    dir("post_rst", 64'd5, 64'd6, 0, 0, 64'd11, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      hold = in_valid && !in_ready;
      @(posedge clk);
      #1 out_ready = $urandom_range(0, 3) != 0;
      if (!hold) begin
        in_valid = $urandom_range(0, 2) != 0;
        a = rnd();
        b = rnd();
        ci = 1'($urandom_range(0, 1));
        op = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    if (in_valid && !in_ready) begin
      @(posedge clk);
      #1 out_ready = 1;
    end
    @(posedge clk);
    #1 in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/suma_c2_seg.md
# suma_c2_seg

Pipelined, parametrised two's-complement adder/subtractor with valid/ready handshake. It generalises the combinational SumaC2 adder: the carry chain is split into `ETAPAS` registered segments, a subtract mode and a signed-overflow flag are added, and a stall-capable pipeline lets it sit directly in the datapath between a producer and a consumer that may back-pressure.

## Interface
- `ANCHO`, 64: operand/result width in bits; must be a multiple of `ETAPAS`.
- `ETAPAS`, 4: number of pipeline segments; each segment handles `ANCHO/ETAPAS` bits; 1 ≤ `ETAPAS` ≤ `ANCHO`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `a`  in  ANCHO  operand A.
- `b`  in  ANCHO  operand B.
- `ci`  in  1  carry-in (add) / borrow-in (subtract).
- `op`  in  1  0 = add, 1 = subtract.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block accepts operands this cycle.
- `s`  out  ANCHO  result.
- `coutfin`  out  1  raw carry-out of the MSB segment.
- `ovf`  out  1  signed overflow of the unsaturated result.
- `out_valid`  out  1  `s`/`coutfin`/`ovf` valid.
- `out_ready`  in  1  consumer accepts the result.

## Operation
- Add: result = `a + b + ci`.
- Subtract: result = `a + ~b + !ci`, i.e. `a - b - ci`; `coutfin` = 1 means no borrow.
- Segment k (0 = LSB) adds its slice of A and the conditioned B plus the carry registered from segment k-1. Lower result slices and not-yet-consumed upper operand slices travel with the token.
- Only the carry is cut between segments; no full-width carry path exists.
- `ovf` = (sign A == sign B′) && (sign result ≠ sign A), where B′ is the conditioned B.
- `coutfin` is the carry out of bit `ANCHO-1`, independent of `ovf` and of saturation.
- `op` and `ci` are captured with the operands; changing them later has no effect on tokens in flight.
- Results leave in acceptance order. No reordering, no dropping.

## Timing
- Latency: `ETAPAS` cycles from the accepting edge (`in_valid && in_ready`) to `out_valid` high. With `ETAPAS`=1, the result is registered one cycle later.
- Throughput: one operation per cycle when `out_ready` is held high.
- Global stall: `adv = !out_valid || out_ready`.
  - `in_ready = adv`, combinational from `out_valid`/`out_ready`.
  - When `adv`=0, every stage register holds.
  - Bubbles do not collapse during a stall.
- Output handshake: `s`, `coutfin` and `ovf` stay stable while `out_valid && !out_ready`.
- Accepting a new operand and retiring a result in the same cycle is allowed; the pipeline shifts by one.
- Reset, synchronous:
  - Clears all stage valid bits, carries and data registers.
  - Outputs after reset: `out_valid`=0, `s`=0, `coutfin`=0, `ovf`=0; `in_ready`=1.
  - A reset mid-operation discards all tokens in flight. No result from before the reset ever appears.
- `in_valid` high while `in_ready` low: the operands are not taken, and the producer must hold them.

## Configuration
- `SUMAC2_SAT_EN` defined: when `ovf`=1, `s` is replaced by the saturated value.
  - `{1'b0, {ANCHO-1{1'b1}}}` if `a[ANCHO-1]`=0.
  - `{1'b1, {ANCHO-1{1'b0}}}` if `a[ANCHO-1]`=1.
  - Saturation is applied in the final segment, with no added latency. `ovf` and `coutfin` still report raw values.
- Not defined: `s` wraps modulo 2^ANCHO, and no saturation logic is built.

## Test plan
- Wrap-around: `ANCHO`=64, `ETAPAS`=4; `a`=FFFF_FFFF_FFFF_FFFF, `b`=1, `ci`=0, `op`=0, out_ready=1.
  - Expect 4 cycles later: `s`=0, `coutfin`=1, `ovf`=0, `out_valid` high for 1 cycle.
- Subtract and borrow-in: `a`=1, `b`=1, `op`=1.
  - `ci`=0 → `s`=0, `coutfin`=1.
  - `ci`=1 → `s`=FFFF_FFFF_FFFF_FFFF, `coutfin`=0, `ovf`=0.
- Negative overflow: `a`=`b`=8000_0000_0000_0000, `op`=0, `ci`=0.
  - Expect `coutfin`=1, `ovf`=1.
  - `s`=0 without `SUMAC2_SAT_EN`; `s`=8000_0000_0000_0000 with it.
- Positive overflow: `a`=7FFF_FFFF_FFFF_FFFF, `b`=1.
  - Expect `ovf`=1, `coutfin`=0.
  - `s`=8000_0000_0000_0000 without `SUMAC2_SAT_EN`; `s`=7FFF_FFFF_FFFF_FFFF with it.
- Back-pressure: stream 8 back-to-back operations (`a`=i, `b`=i, i=1..8); drop `out_ready` for 3 cycles after the first result.
  - Expect `in_ready`=0 during the stall and outputs held stable.
  - All 8 sums (2,4,…,16) delivered in order, with no duplicates.
- Reset mid-flight: accept 3 operations, assert `rst` for 1 cycle while they are in flight.
  - Expect `out_valid`=0 and `s`=0 on the next cycle, and none of the 3 results ever appearing.
  - A post-reset operation returns after exactly `ETAPAS` cycles.
